// File: rtl/config_loader.sv
// config_loader: loads one configuration shift chain from a word stream.
// Each accepted word is serialized LSB first onto shift_data/shift_en. When
// CHAIN_LENGTH bits have been shifted, set pulses for one cycle to capture the
// chain into the config latches, and done pulses on the following cycle.
// Optional checksum stage: define CONFIG_LOADER_CHECK_EN to enable it. It
// XOR-folds every data word and requires a matching checksum word before set.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_SHIFT | accepting and serializing data words
// S_CHECK | waiting for the checksum word (check build only)
// S_LATCH | set pulse to the config latches
// S_DONE  | done pulse, then back to idle
module config_loader #(
    parameter int CHAIN_LENGTH = 64,
    parameter int WORD_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_en,
    output logic              shift_data,
    output logic              set,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int NWORDS = CHAIN_LENGTH / WORD_W;
    localparam int CNT_W  = $clog2(NWORDS + 1);
    localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef CONFIG_LOADER_CHECK_EN
        S_CHECK,
`endif
        S_LATCH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  sreg_q, sreg_d;
    logic [BIT_W-1:0]   bits_q, bits_d;
    logic               shift_en_q, shift_en_d;
    logic               shift_data_q, shift_data_d;
    logic               set_q, set_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ser_free;
    logic               in_ready_c;
    logic               accept;
`ifdef CONFIG_LOADER_CHECK_EN
    logic [WORD_W-1:0]  acc_q, acc_d;
    logic               error_q, error_d;
`endif

    // The serializer can take a new word when idle or emitting its final bit,
    // which is what lets back-to-back words stream without a gap.
    assign ser_free = ~shift_en_q | (bits_q == '0);

    // Ready decode: only while loading, never while abort is high.
    always_comb begin
        in_ready_c = 1'b0;
        if (!abort) begin
            if (state_q == S_SHIFT) begin
                in_ready_c = ser_free & (cnt_q < LAST_CNT);
            end
`ifdef CONFIG_LOADER_CHECK_EN
            else if (state_q == S_CHECK) begin
                in_ready_c = ser_free;
            end
`endif
        end
    end

    assign accept = in_valid & in_ready_c;

    // Next-state, serializer and registered-output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        bits_d       = bits_q;
        shift_en_d   = 1'b0;
        shift_data_d = 1'b0;
        set_d        = 1'b0;
        done_d       = 1'b0;
`ifdef CONFIG_LOADER_CHECK_EN
        acc_d        = acc_q;
        error_d      = error_q;
`endif

        // Keep draining the current word; a new acceptance below overrides this.
        if (shift_en_q && (bits_q != '0)) begin
            shift_en_d   = 1'b1;
            shift_data_d = sreg_q[0];
            sreg_d       = sreg_q >> 1;
            bits_d       = bits_q - BIT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
`ifdef CONFIG_LOADER_CHECK_EN
                    acc_d   = '0;
                    error_d = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d      = S_IDLE;
                    shift_en_d   = 1'b0;
                    shift_data_d = 1'b0;
                    sreg_d       = '0;
                    bits_d       = '0;
                end else if (accept) begin
                    shift_en_d   = 1'b1;
                    shift_data_d = in_data[0];
                    sreg_d       = in_data >> 1;
                    bits_d       = LAST_BIT;
                    cnt_d        = cnt_q + CNT_W'(1);
`ifdef CONFIG_LOADER_CHECK_EN
                    acc_d        = acc_q ^ in_data;
`endif
                end else if ((cnt_q == LAST_CNT) && shift_en_q && (bits_q == '0)) begin
`ifdef CONFIG_LOADER_CHECK_EN
                    state_d = S_CHECK;
`else
                    state_d = S_LATCH;
                    set_d   = 1'b1;
`endif
                end
            end
`ifdef CONFIG_LOADER_CHECK_EN
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (accept) begin
                    if (in_data == acc_q) begin
                        state_d = S_LATCH;
                        set_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_LATCH: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops everything, set is never issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            bits_q       <= '0;
            shift_en_q   <= 1'b0;
            shift_data_q <= 1'b0;
            set_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            bits_q       <= bits_d;
            shift_en_q   <= shift_en_d;
            shift_data_q <= shift_data_d;
            set_q        <= set_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

`ifdef CONFIG_LOADER_CHECK_EN
    // Checksum accumulator and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            error_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign in_ready   = in_ready_c;
    assign shift_en   = shift_en_q;
    assign shift_data = shift_data_q;
    assign set        = set_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader at CHAIN_LENGTH=16, WORD_W=8. A per-cycle vector
// table covers the gapless load; hand sequences cover backpressure, abort,
// illegal start, reset mid-load and (check build) checksum mismatch.
module tb_config_loader;

    localparam int CL = 16;
    localparam int WW = 8;
`ifdef CONFIG_LOADER_CHECK_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int SET_OFF = 1 + CK;   // set cycle relative to last shift cycle
    localparam int NROWS   = 22 + CK;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data  = '0;
    logic          in_ready, shift_en, shift_data, set, busy, done, error;

    config_loader #(.CHAIN_LENGTH(CL), .WORD_W(WW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .shift_en(shift_en), .shift_data(shift_data), .set(set),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          s, a, v;
        logic [WW-1:0] d;
        logic          rdy, sen, sdat, st, bsy, dn;
    } vec_t;

    vec_t        tbl [NROWS];
    logic [15:0] exp_bits;

    int n_checks = 0;
    int n_errors = 0;

    // monitor state, refreshed by every cycle() call
    int          cyc, sh_cnt, first_sh, last_sh, set_cnt, set_cyc;
    int          done_cnt, done_cyc, acc_cnt, sd_bad;
    logic [31:0] sh_bits;
    logic        last_acc;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [%0d]: got 0x%0h want 0x%0h", name, tag, act, exp);
        end
    endtask

    task automatic mon_clear();
        cyc = 0; sh_cnt = 0; first_sh = -1; last_sh = -1; set_cnt = 0; set_cyc = -1;
        done_cnt = 0; done_cyc = -1; acc_cnt = 0; sd_bad = 0; sh_bits = '0; last_acc = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample 1 ns later, well before posedge.
    task automatic cycle(input logic s, input logic a, input logic v, input logic [WW-1:0] d);
        @(negedge clk);
        start = s; abort = a; in_valid = v; in_data = d;
        #1;
        last_acc = in_valid & in_ready;
        if (last_acc) acc_cnt++;
        if (shift_en) begin
            if (sh_cnt < 32) sh_bits[sh_cnt] = shift_data;
            if (first_sh < 0) first_sh = cyc;
            last_sh = cyc;
            sh_cnt++;
        end else if (shift_data) begin
            sd_bad++;
        end
        if (set) begin set_cnt++; set_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        cyc++;
    endtask

    task automatic offer(input logic [WW-1:0] w);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle(1'b0, 1'b0, 1'b1, w);
            got = last_acc;
        end
        chk("offer_accepted", int'(w), got, 1);
    endtask

    // Keep a (checksum) word valid until the loader returns to idle.
    task automatic finish_load(input logic [WW-1:0] ck);
        for (int k = 0; k < 60; k++) begin
            cycle(1'b0, 1'b0, 1'b1, ck);
            if (!busy) break;
        end
        chk("load_idle", 0, busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_in_ready"},   0, in_ready,   0);
        chk({name, "_shift_en"},   0, shift_en,   0);
        chk({name, "_shift_data"}, 0, shift_data, 0);
        chk({name, "_set"},        0, set,        0);
        chk({name, "_busy"},       0, busy,       0);
        chk({name, "_done"},       0, done,       0);
        chk({name, "_error"},      0, error,      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_bits = 16'h3CA5;   // A5 then 3C, bit 0 of each shifted first

        // gapless load table
        for (int i = 0; i < NROWS; i++) tbl[i] = '0;
        tbl[0].s = 1'b1;
        tbl[1].v = 1'b1; tbl[1].d = 8'hA5; tbl[1].rdy = 1'b1; tbl[1].bsy = 1'b1;
        for (int i = 2; i <= 17; i++) begin
            tbl[i].bsy  = 1'b1;
            tbl[i].sen  = 1'b1;
            tbl[i].sdat = exp_bits[i-2];
            if (i <= 9) begin tbl[i].v = 1'b1; tbl[i].d = 8'h3C; end
            if (i == 9) tbl[i].rdy = 1'b1;
            if (i >= 10 && i <= 12) begin tbl[i].v = 1'b1; tbl[i].d = 8'h77; end
        end
        if (CK == 1) begin
            tbl[18].v = 1'b1; tbl[18].d = 8'h99; tbl[18].rdy = 1'b1; tbl[18].bsy = 1'b1;
        end
        tbl[18+CK].a = 1'b1; tbl[18+CK].st = 1'b1; tbl[18+CK].bsy = 1'b1;
        tbl[19+CK].a = 1'b1; tbl[19+CK].dn = 1'b1; tbl[19+CK].bsy = 1'b1;

        mon_clear();

        // reset values
        @(negedge clk); #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // gapless load, abort during LATCH/DONE ignored
        for (int r = 0; r < NROWS; r++) begin
            cycle(tbl[r].s, tbl[r].a, tbl[r].v, tbl[r].d);
            chk("tbl_in_ready",   r, in_ready,   tbl[r].rdy);
            chk("tbl_shift_en",   r, shift_en,   tbl[r].sen);
            chk("tbl_shift_data", r, shift_data, tbl[r].sdat);
            chk("tbl_set",        r, set,        tbl[r].st);
            chk("tbl_busy",       r, busy,       tbl[r].bsy);
            chk("tbl_done",       r, done,       tbl[r].dn);
            chk("tbl_error",      r, error,      0);
        end

        // backpressure: 3-cycle hole in shift_en, same bit order
        mon_clear();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        offer(8'hA5);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        offer(8'h3C);
        finish_load(8'h99);
        chk("bp_shift_cnt", 0, sh_cnt, 16);
        chk("bp_bits",      0, sh_bits[15:0], exp_bits);
        chk("bp_gap",       0, last_sh - first_sh + 1 - 16, 3);
        chk("bp_set_cnt",   0, set_cnt, 1);
        chk("bp_set_cyc",   0, set_cyc, last_sh + SET_OFF);
        chk("bp_done_cyc",  0, done_cyc, set_cyc + 1);
        chk("bp_sd_idle",   0, sd_bad, 0);

        // abort after the 5th shifted bit
        mon_clear();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        offer(8'hA5);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ab_bits_before", 0, sh_cnt, 5);
        cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        chk("ab_ready_during", 0, in_ready, 0);
        cycle(1'b0, 1'b0, 1'b1, 8'h3C);
        chk("ab_busy_after",  0, busy, 0);
        chk("ab_shen_after",  0, shift_en, 0);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1, 8'h3C);
        chk("ab_accepts",     0, acc_cnt, 1);
        chk("ab_set_cnt",     0, set_cnt, 0);
        chk("ab_shift_cnt",   0, sh_cnt, 6);

        // start and abort together in idle starts; abort then forces ready low
        mon_clear();
        cycle(1'b1, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'hA5);
        chk("sa_busy",      0, busy, 1);
        chk("sa_ready_ab",  0, in_ready, 0);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("sa_busy_after", 0, busy, 0);

        // start during SHIFT is ignored and keeps the word count
        mon_clear();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        offer(8'hA5);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        offer(8'h3C);
        finish_load(8'h99);
        chk("is_shift_cnt", 0, sh_cnt, 16);
        chk("is_bits",      0, sh_bits[15:0], exp_bits);
        chk("is_set_cnt",   0, set_cnt, 1);
        chk("is_done_cnt",  0, done_cnt, 1);

        // asynchronous reset mid-SHIFT
        mon_clear();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        offer(8'hA5);
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rs_shifting", 0, shift_en, 1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 1'b1, 8'h3C);
        chk("rs_set_cnt", 0, set_cnt, 0);
        chk("rs_busy",    0, busy, 0);
        chk("rs_accepts", 0, acc_cnt, 1);

`ifdef CONFIG_LOADER_CHECK_EN
        // checksum mismatch: error, no set; next start clears error
        mon_clear();
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        offer(8'hA5);
        offer(8'h3C);
        finish_load(8'h98);
        chk("ck_bad_set",   0, set_cnt, 0);
        chk("ck_bad_error", 0, error, 1);
        chk("ck_bad_shift", 0, sh_cnt, 16);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ck_err_sticky", 0, error, 1);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ck_err_clear", 0, error, 0);
        chk("ck_restart",   0, busy, 1);
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ck_abort_idle", 0, busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
